// File: rtl/vga_timing_pkg.sv
// Shared timing constants, sync polarity codes and pixel type for the VGA raster sequencer.
package vga_timing_pkg;

  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;

  localparam int unsigned DEF_H_TOTAL =
    DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int unsigned DEF_V_TOTAL =
    DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam bit SYNC_POL_LOW  = 1'b1;
  localparam bit SYNC_POL_HIGH = 1'b0;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  // Bits needed to hold 0..total-1.
  function automatic int cnt_width(input int unsigned total);
    return (total <= 1) ? 1 : $clog2(total);
  endfunction

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// Pixel bus between the raster sequencer (master) and the render logic (slave).
interface vga_timing_ctrl_if #(
  parameter int H_CNT_WID = 10,
  parameter int V_CNT_WID = 10
);

  logic [H_CNT_WID-1:0] H_CNT;
  logic [V_CNT_WID-1:0] next_V_CNT;
  logic                 H_BLANKING;
  logic                 NEXT_FRAME;
  logic [3:0]           r;
  logic [3:0]           g;
  logic [3:0]           b;

  modport master (
    output H_CNT, next_V_CNT, H_BLANKING, NEXT_FRAME,
    input  r, g, b
  );

  modport slave (
    input  H_CNT, next_V_CNT, H_BLANKING, NEXT_FRAME,
    output r, g, b
  );

endinterface

// File: rtl/wrap_counter.sv
// Enabled counter running 0..MAX; wrap flags the terminal count so it can chain.
module wrap_counter #(
  parameter int WID = 10,
  parameter int MAX = 799
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  output logic [WID-1:0] cnt,
  output logic           wrap
);

  assign wrap = (cnt == WID'(MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n)
      cnt <= '0;
    else if (en)
      cnt <= wrap ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster sequencer: drives the pixel bus positions and registers blanked pixel + syncs to the pins.
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE       = DEF_H_VISIBLE,
  parameter int H_FRONT         = DEF_H_FRONT,
  parameter int H_SYNC          = DEF_H_SYNC,
  parameter int H_BACK          = DEF_H_BACK,
  parameter int V_VISIBLE       = DEF_V_VISIBLE,
  parameter int V_FRONT         = DEF_V_FRONT,
  parameter int V_SYNC          = DEF_V_SYNC,
  parameter int V_BACK          = DEF_V_BACK,
  parameter bit SYNC_ACTIVE_LOW = SYNC_POL_LOW,
  parameter int H_CNT_WID       = cnt_width(DEF_H_TOTAL),
  parameter int V_CNT_WID       = cnt_width(DEF_V_TOTAL)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              PIX_CE,
  vga_timing_ctrl_if.master bus,
  output logic [3:0]        VGA_R,
  output logic [3:0]        VGA_G,
  output logic [3:0]        VGA_B,
  output logic              HSYNC,
  output logic              VSYNC
);

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam int VS_END   = VS_START + V_SYNC;

  if (2**H_CNT_WID < H_TOTAL) begin : g_h_wid_err
    $fatal(1, "H_CNT_WID cannot hold H_TOTAL-1");
  end
  if (2**V_CNT_WID < V_TOTAL) begin : g_v_wid_err
    $fatal(1, "V_CNT_WID cannot hold V_TOTAL-1");
  end

  logic [H_CNT_WID-1:0] h_cnt;
  logic [V_CNT_WID-1:0] v_cnt;
  logic                 h_wrap;
  logic                 v_wrap;
  logic                 v_blank;
  logic                 hsync_act;
  logic                 vsync_act;
  rgb_t                 pix_q;

  wrap_counter #(.WID(H_CNT_WID), .MAX(H_TOTAL - 1)) u_h_cnt (
    .clk   (CLK),
    .rst_n (RST_N),
    .en    (PIX_CE),
    .cnt   (h_cnt),
    .wrap  (h_wrap)
  );

  // The line counter steps only on the pixel edge that ends a line.
  wrap_counter #(.WID(V_CNT_WID), .MAX(V_TOTAL - 1)) u_v_cnt (
    .clk   (CLK),
    .rst_n (RST_N),
    .en    (PIX_CE & h_wrap),
    .cnt   (v_cnt),
    .wrap  (v_wrap)
  );

  assign bus.H_CNT      = h_cnt;
  assign bus.next_V_CNT = v_wrap ? '0 : v_cnt + 1'b1;
  assign bus.H_BLANKING = (h_cnt >= H_CNT_WID'(H_VISIBLE));
  assign v_blank        = (v_cnt >= V_CNT_WID'(V_VISIBLE));

  // Gated by PIX_CE so the pulse is a single CLK wide even with a slow pixel rate.
  assign bus.NEXT_FRAME = PIX_CE && (h_cnt == '0) && (v_cnt == V_CNT_WID'(V_VISIBLE));

  assign hsync_act = (h_cnt >= H_CNT_WID'(HS_START)) && (h_cnt < H_CNT_WID'(HS_END));
  assign vsync_act = (v_cnt >= V_CNT_WID'(VS_START)) && (v_cnt < V_CNT_WID'(VS_END));

  // Pixel and syncs share one register stage so they leave the chip aligned.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pix_q <= '0;
      HSYNC <= SYNC_ACTIVE_LOW;
      VSYNC <= SYNC_ACTIVE_LOW;
    end else if (PIX_CE) begin
      pix_q <= (bus.H_BLANKING | v_blank) ? '0 : rgb_t'{bus.r, bus.g, bus.b};
      HSYNC <= hsync_act ^ SYNC_ACTIVE_LOW;
      VSYNC <= vsync_act ^ SYNC_ACTIVE_LOW;
    end
  end

  assign VGA_R = pix_q.r;
  assign VGA_G = pix_q.g;
  assign VGA_B = pix_q.b;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl on a shrunken raster, checked against a pixel-index reference model.
module tb_vga_timing_ctrl;

  localparam int HV = 16, HF = 4, HS = 6, HB = 6;
  localparam int VV = 12, VF = 2, VS = 2, VB = 4;
  localparam int HT = HV + HF + HS + HB;   // 32
  localparam int VT = VV + VF + VS + VB;   // 20
  localparam int FRAME = HT * VT;          // 640
  localparam int HW = 5, VW = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pix_ce = 1'b0;
  logic [3:0] vga_r, vga_g, vga_b;
  logic       hsync, vsync;

  vga_timing_ctrl_if #(.H_CNT_WID(HW), .V_CNT_WID(VW)) bus ();

  vga_timing_ctrl #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_ACTIVE_LOW(1'b1), .H_CNT_WID(HW), .V_CNT_WID(VW)
  ) dut (
    .CLK    (clk),
    .RST_N  (rst_n),
    .PIX_CE (pix_ce),
    .bus    (bus.master),
    .VGA_R  (vga_r),
    .VGA_G  (vga_g),
    .VGA_B  (vga_b),
    .HSYNC  (hsync),
    .VSYNC  (vsync)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail = 0;
  int          pix = 0;      // pixel edges accepted since the last reset
  int          cyc = 0;
  bit          const_f = 1'b0;
  logic [11:0] exp_rgb = '0;
  logic        exp_hs = 1'b1;
  logic        exp_vs = 1'b1;
  int          nf_cyc[$];

  function automatic int hpos(input int p);
    return p % HT;
  endfunction

  function automatic int vpos(input int p);
    return (p / HT) % VT;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_h_cnt"}, 32'(bus.H_CNT), 0);
    check({tag, "_next_v"}, 32'(bus.next_V_CNT), 1);
    check({tag, "_nf"}, 32'(bus.NEXT_FRAME), 0);
    check({tag, "_vga"}, {20'd0, vga_r, vga_g, vga_b}, 0);
    check({tag, "_hsync"}, 32'(hsync), 1);
    check({tag, "_vsync"}, 32'(vsync), 1);
  endtask

  // One CLK cycle: drive at negedge, check bus outputs, then check the registered pins after posedge.
  task automatic step(input logic ce);
    int h, v;
    @(negedge clk);
    pix_ce = ce;
    if (const_f) {bus.r, bus.g, bus.b} = 12'hFFF;
    else         {bus.r, bus.g, bus.b} = 12'($urandom);
    #1;
    h = hpos(pix);
    v = vpos(pix);
    check("h_cnt", 32'(bus.H_CNT), h);
    check("next_v_cnt", 32'(bus.next_V_CNT), (v + 1) % VT);
    check("h_blanking", 32'(bus.H_BLANKING), (h >= HV) ? 1 : 0);
    check("next_frame", 32'(bus.NEXT_FRAME), (ce && h == 0 && v == VV) ? 1 : 0);
    if (bus.NEXT_FRAME === 1'b1) nf_cyc.push_back(cyc);
    if (ce) begin
      exp_rgb = (h < HV && v < VV) ? {bus.r, bus.g, bus.b} : 12'h000;
      exp_hs  = !(h >= HV + HF && h < HV + HF + HS);
      exp_vs  = !(v >= VV + VF && v < VV + VF + VS);
      pix++;
    end
    @(posedge clk);
    #1;
    cyc++;
    check("vga_rgb", {20'd0, vga_r, vga_g, vga_b}, {20'd0, exp_rgb});
    check("hsync", 32'(hsync), 32'(exp_hs));
    check("vsync", 32'(vsync), 32'(exp_vs));
  endtask

  task automatic run_to(input int h, input int v);
    for (int k = 0; k < FRAME && !(hpos(pix) == h && vpos(pix) == v); k++) step(1'b1);
  endtask

  // Reset lands mid-cycle; outputs must change before any clock edge.
  task automatic mid_reset(input string tag);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values(tag);
    pix = 0;
    exp_rgb = '0;
    exp_hs = 1'b1;
    exp_vs = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pix_ce = 1'b0;
    rst_n = 1'b1;
  endtask

  initial begin
    int diff;
    {bus.r, bus.g, bus.b} = 12'h000;
    pix_ce = 1'b1;
    rst_n = 1'b0;
    #12;
    check_reset_values("por");
    @(negedge clk);
    pix_ce = 1'b0;
    rst_n = 1'b1;

    // Full frame with a white producer: blanking and sync windows.
    const_f = 1'b1;
    repeat (FRAME) step(1'b1);

    // Second frame with random pixels; ends on the (HT-1, VT-1) -> (0,0) wrap.
    const_f = 1'b0;
    repeat (FRAME) step(1'b1);
    #1;
    check("wrap_h_cnt", 32'(bus.H_CNT), 0);
    check("wrap_next_v", 32'(bus.next_V_CNT), 1);
    check("wrap_no_nf", 32'(bus.NEXT_FRAME), 0);
    diff = (nf_cyc.size() >= 2) ? nf_cyc[1] - nf_cyc[0] : -1;
    check("nf_count", 32'(nf_cyc.size()), 2);
    check("nf_interval", 32'(diff), FRAME);

    // Alternating enable across a frame boundary, then random enable.
    for (int i = 0; i < 2 * FRAME + 64; i++) step((i % 2) == 0);
    repeat (1500) step(1'($urandom_range(0, 1)));

    // Reset inside the visible area with white pixels on the pins.
    const_f = 1'b1;
    run_to(10, 5);
    step(1'b1);
    check("pre_reset_vga", {20'd0, vga_r, vga_g, vga_b}, 32'hFFF);
    mid_reset("rst_vis");
    repeat (40) step(1'b1);

    // Reset while both syncs are active.
    const_f = 1'b0;
    run_to(22, 14);
    step(1'b1);
    check("pre_reset_syncs", {30'd0, hsync, vsync}, 0);
    mid_reset("rst_sync");
    repeat (FRAME + 40) step(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
